// File: rtl/vram_arbiter.sv
// Pixel RAM arbiter: VGA reads win, buffered pixel writes and a clear-screen
// fill engine share the remaining (rdn high) cycles, fill taking precedence.
module vram_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ROWS       = 480,
   parameter int unsigned COLS       = 640
) (
   input  logic        vga_clk,
   input  logic        clrn,
   input  logic        rdn,
   input  logic [8:0]  row_addr,
   input  logic [9:0]  col_addr,
   output logic [11:0] d_out,
   input  logic        wr_req,
   input  logic [8:0]  wr_row,
   input  logic [9:0]  wr_col,
   input  logic [11:0] wr_data,
   output logic        wr_ready,
   input  logic        fill_start,
   input  logic [11:0] fill_color,
   output logic        fill_busy,
   output logic [18:0] mem_addr,
   output logic        mem_we,
   output logic [11:0] mem_wdata,
   input  logic [11:0] mem_rdata
);

   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam logic [8:0]  ROW_LAST = 9'(ROWS - 1);
   localparam logic [9:0]  COL_LAST = 10'(COLS - 1);

   typedef enum logic {
      S_IDLE,
      S_FILL
   } fill_state_e;

   fill_state_e state_q;
   logic [8:0]  fill_row_q;
   logic [9:0]  fill_col_q;
   logic [11:0] fill_color_q;
   logic        fill_busy_q;

   // Entry layout: {row[8:0], col[9:0], data[11:0]}
   logic [30:0] fifo_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [30:0] fifo_head;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic        issue_fill;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_head  = fifo_q[rd_ptr_q[AW-1:0]];

   assign push       = wr_req && !fifo_full;
   assign issue_fill = rdn && (state_q == S_FILL);
   // The FIFO only drains once the fill engine has returned to idle.
   assign pop        = rdn && (state_q == S_IDLE) && !fifo_empty;

   assign wr_ready  = !fifo_full;
   assign fill_busy = fill_busy_q;
   assign d_out     = mem_rdata;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = {row_addr, col_addr};
      mem_wdata = '0;
      if (issue_fill) begin
         mem_we    = 1'b1;
         mem_addr  = {fill_row_q, fill_col_q};
         mem_wdata = fill_color_q;
      end else if (pop) begin
         mem_we    = 1'b1;
         mem_addr  = fifo_head[30:12];
         mem_wdata = fifo_head[11:0];
      end
   end

   always_ff @(posedge vga_clk) begin
      if (push) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= {wr_row, wr_col, wr_data};
      end
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= S_IDLE;
         fill_row_q   <= '0;
         fill_col_q   <= '0;
         fill_color_q <= '0;
         fill_busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fill_start) begin
                  state_q      <= S_FILL;
                  fill_color_q <= fill_color;
                  fill_row_q   <= '0;
                  fill_col_q   <= '0;
                  fill_busy_q  <= 1'b1;
               end
            end
            S_FILL: begin
               if (rdn) begin
                  if (fill_col_q == COL_LAST) begin
                     fill_col_q <= '0;
                     if (fill_row_q == ROW_LAST) begin
                        fill_row_q  <= '0;
                        state_q     <= S_IDLE;
                        fill_busy_q <= 1'b0;
                     end else begin
                        fill_row_q <= fill_row_q + 9'd1;
                     end
                  end else begin
                     fill_col_q <= fill_col_q + 10'd1;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               fill_busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter on a reduced screen; a negedge monitor pops
// expected RAM writes (fill queue first, then FIFO queue) and checks each one.
module tb_vram_arbiter;

   localparam int unsigned TR = 6;
   localparam int unsigned TC = 10;

   typedef struct packed {
      logic [18:0] addr;
      logic [11:0] data;
   } wr_t;

   logic        vga_clk;
   logic        clrn;
   logic        rdn;
   logic [8:0]  row_addr;
   logic [9:0]  col_addr;
   logic [11:0] d_out;
   logic        wr_req;
   logic [8:0]  wr_row;
   logic [9:0]  wr_col;
   logic [11:0] wr_data;
   logic        wr_ready;
   logic        fill_start;
   logic [11:0] fill_color;
   logic        fill_busy;
   logic [18:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;

   int   total;
   int   bad;
   int   writes_seen;
   wr_t  exp_fill[$];
   wr_t  exp_fifo[$];

   vram_arbiter #(
      .FIFO_DEPTH(4),
      .ROWS      (TR),
      .COLS      (TC)
   ) dut (
      .vga_clk   (vga_clk),
      .clrn      (clrn),
      .rdn       (rdn),
      .row_addr  (row_addr),
      .col_addr  (col_addr),
      .d_out     (d_out),
      .wr_req    (wr_req),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .fill_start(fill_start),
      .fill_color(fill_color),
      .fill_busy (fill_busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic push_fill(input logic [11:0] color);
      wr_t e;
      for (int r = 0; r < int'(TR); r++) begin
         for (int c = 0; c < int'(TC); c++) begin
            e.addr = {9'(r), 10'(c)};
            e.data = color;
            exp_fill.push_back(e);
         end
      end
   endtask

   task automatic expect_fifo(input logic [8:0] r, input logic [9:0] c, input logic [11:0] d);
      wr_t e;
      e.addr = {r, c};
      e.data = d;
      exp_fifo.push_back(e);
   endtask

   // Scoreboard: every RAM write must match the oldest outstanding expectation.
   always @(negedge vga_clk) begin
      wr_t e;
      if (clrn === 1'b1 && mem_we !== 1'b0) begin
         writes_seen++;
         if (exp_fill.size() > 0) begin
            e = exp_fill.pop_front();
            check("wr_addr", {13'd0, mem_addr}, {13'd0, e.addr});
            check("wr_data", {20'd0, mem_wdata}, {20'd0, e.data});
            check("we_only_when_rdn_high", {31'd0, rdn}, 32'd1);
         end else if (exp_fifo.size() > 0) begin
            e = exp_fifo.pop_front();
            check("wr_addr", {13'd0, mem_addr}, {13'd0, e.addr});
            check("wr_data", {20'd0, mem_wdata}, {20'd0, e.data});
            check("we_only_when_rdn_high", {31'd0, rdn}, 32'd1);
         end else begin
            check("spurious_we", {31'd0, mem_we}, 32'd0);
         end
      end
   end

   initial begin
      int cycles;
      int base;
      total = 0;
      bad = 0;
      writes_seen = 0;
      clrn = 1'b0;
      rdn = 1'b1;
      row_addr = '0;
      col_addr = '0;
      wr_req = 1'b0;
      wr_row = '0;
      wr_col = '0;
      wr_data = '0;
      fill_start = 1'b0;
      fill_color = '0;
      mem_rdata = '0;

      // Reset state
      #2;
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("rst_fill_busy", {31'd0, fill_busy}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_wdata", {20'd0, mem_wdata}, 32'd0);
      tick();
      clrn = 1'b1;
      repeat (3) tick();

      // Fill the FIFO while VGA reads hold the bus
      rdn = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         check("wr_ready_before_push", {31'd0, wr_ready}, 32'd1);
         wr_req = 1'b1;
         wr_row = 9'(i);
         wr_col = '0;
         wr_data = 12'(12'h100 + i);
         expect_fifo(9'(i), 10'd0, 12'(12'h100 + i));
         tick();
         wr_req = 1'b0;
         check("no_we_while_reading", {31'd0, mem_we}, 32'd0);
      end
      check("wr_ready_full", {31'd0, wr_ready}, 32'd0);
      wr_req = 1'b1;
      wr_row = 9'd7;
      wr_col = 10'd7;
      wr_data = 12'hEEE;
      tick();
      wr_req = 1'b0;

      // Read priority with pending FIFO entries
      row_addr = 9'd5;
      col_addr = 10'd7;
      mem_rdata = 12'hABC;
      #1;
      check("rd_mem_addr", {13'd0, mem_addr}, 32'h01407);
      check("rd_mem_we", {31'd0, mem_we}, 32'd0);
      check("rd_d_out", {20'd0, d_out}, 32'hABC);
      check("rd_fifo_untouched", {31'd0, wr_ready}, 32'd0);
      tick();

      // Drain: four consecutive writes once rdn rises
      rdn = 1'b1;
      repeat (4) tick();
      check("drain_consecutive", exp_fifo.size(), 32'd0);
      check("wr_ready_after_drain", {31'd0, wr_ready}, 32'd1);

      // Write latency and simultaneous push/pop streaming
      for (int j = 0; j < 5; j++) begin
         wr_req = 1'b1;
         wr_row = 9'(20 + j);
         wr_col = 10'(100 + j);
         wr_data = 12'(12'h200 + j);
         expect_fifo(9'(20 + j), 10'(100 + j), 12'(12'h200 + j));
         if (j == 0) begin
            #2;
            check("latency_same_cycle", {31'd0, mem_we}, 32'd0);
         end
         check("stream_wr_ready", {31'd0, wr_ready}, 32'd1);
         tick();
      end
      wr_req = 1'b0;
      repeat (2) tick();
      check("stream_drained", exp_fifo.size(), 32'd0);

      // Full-screen fill with rdn held high
      fill_color = 12'h0F0;
      fill_start = 1'b1;
      #2;
      check("fill_busy_start_cycle", {31'd0, fill_busy}, 32'd0);
      tick();
      fill_start = 1'b0;
      fill_color = 12'h000;
      push_fill(12'h0F0);
      check("fill_busy_set", {31'd0, fill_busy}, 32'd1);
      cycles = 0;
      while (exp_fill.size() > 0 && cycles < int'(TR * TC) + 20) begin
         tick();
         cycles++;
      end
      check("fill_done", exp_fill.size(), 32'd0);
      check("fill_cycles", cycles, TR * TC);
      check("fill_busy_clear", {31'd0, fill_busy}, 32'd0);
      repeat (4) tick();

      // Fill interleaved with VGA timing, FIFO write queued beforehand
      rdn = 1'b0;
      wr_req = 1'b1;
      wr_row = 9'd2;
      wr_col = 10'd3;
      wr_data = 12'h456;
      expect_fifo(9'd2, 10'd3, 12'h456);
      tick();
      wr_req = 1'b0;
      fill_color = 12'h123;
      fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      push_fill(12'h123);
      cycles = 0;
      while ((exp_fill.size() > 0 || exp_fifo.size() > 0) && cycles < 2000) begin
         rdn = (cycles % 5) >= 3;
         fill_start = (cycles == 20);
         fill_color = (cycles == 20) ? 12'hFFF : 12'h000;
         if (cycles == 20) check("busy_mid_fill", {31'd0, fill_busy}, 32'd1);
         tick();
         cycles++;
      end
      fill_start = 1'b0;
      rdn = 1'b1;
      check("interleave_done", exp_fill.size() + exp_fifo.size(), 32'd0);
      tick();
      check("interleave_busy_clear", {31'd0, fill_busy}, 32'd0);
      check("interleave_wr_ready", {31'd0, wr_ready}, 32'd1);
      repeat (3) tick();

      // Reset mid-fill with a queued FIFO write
      base = writes_seen;
      fill_color = 12'h0AA;
      fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      push_fill(12'h0AA);
      wr_req = 1'b1;
      wr_row = 9'd9;
      wr_col = 10'd9;
      wr_data = 12'h999;
      expect_fifo(9'd9, 10'd9, 12'h999);
      tick();
      wr_req = 1'b0;
      cycles = 0;
      while (writes_seen < base + 25 && cycles < 200) begin
         tick();
         cycles++;
      end
      check("midfill_progress", {31'd0, writes_seen >= base + 25}, 32'd1);
      clrn = 1'b0;
      #1;
      check("midrst_fill_busy", {31'd0, fill_busy}, 32'd0);
      check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
      check("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
      exp_fill.delete();
      exp_fifo.delete();
      repeat (2) tick();
      clrn = 1'b1;
      repeat (5) tick();
      check("post_rst_idle_we", {31'd0, mem_we}, 32'd0);
      fill_color = 12'h555;
      fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      push_fill(12'h555);
      #1;
      check("restart_addr", {13'd0, mem_addr}, 32'd0);
      cycles = 0;
      while (exp_fill.size() > 0 && cycles < int'(TR * TC) + 20) begin
         tick();
         cycles++;
      end
      check("restart_done", exp_fill.size(), 32'd0);
      check("restart_busy_clear", {31'd0, fill_busy}, 32'd0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single-port pixel RAM (512 rows x 1024 cols, 12-bit bbbb_gggg_rrrr) shared by the VGA scan-out reader and the drawing/game logic.
- VGA reads have absolute priority. Pixel writes are buffered in a small FIFO and retired only on cycles when the VGA is not reading (blanking, or rdn high).
- Contains a clear-screen fill engine that paints the visible 640x480 area with one colour using only free cycles.

Parameters:
- FIFO_DEPTH, 4, write-buffer entries; power of 2, >= 2.
- ROWS, 480, visible lines swept by the fill engine.
- COLS, 640, visible pixels per line swept by the fill engine.

Ports:
- vga_clk  input  1  pixel clock, 25 MHz, sole clock.
- clrn  input  1  asynchronous active-low reset.
- rdn  input  1  VGA read request, active low.
- row_addr  input  9  VGA read row.
- col_addr  input  10  VGA read column.
- d_out  output  12  read pixel returned to the VGA controller's d_in.
- wr_req  input  1  write request; accepted on a clock edge where wr_req && wr_ready.
- wr_row  input  9  write row.
- wr_col  input  10  write column.
- wr_data  input  12  write pixel.
- wr_ready  output  1  FIFO not full.
- fill_start  input  1  single-cycle pulse that starts a full-screen fill.
- fill_color  input  12  fill colour; sampled on the accepted fill_start.
- fill_busy  output  1  fill in progress.
- mem_addr  output  19  RAM address {row[8:0], col[9:0]}.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  12  RAM write data.
- mem_rdata  input  12  RAM read data (RAM is asynchronous-read, or its latency is absorbed upstream).

Behaviour:
- Reset (clrn low, asynchronous):
  - FIFO emptied; fill engine idle; fill row/col counters = 0.
  - Outputs while reset is held: wr_ready=1, fill_busy=0, mem_we=0, mem_wdata=0.
- Reset mid-fill or with FIFO entries: fill aborted, queued writes discarded, no further mem_we.
- Read path (combinational):
  - When rdn=0: mem_addr={row_addr,col_addr}, mem_we=0, regardless of fill or FIFO state.
  - d_out=mem_rdata at all times.
- Free cycle: any cycle with rdn=1. Exactly one write is issued per free cycle if work is pending. Priority is fill, then FIFO.
- Issued write: mem_we=1, with mem_addr/mem_wdata from the fill counters or the FIFO head. The issuing source advances at the end of that cycle.
- Free cycle with nothing pending: mem_we=0, mem_addr={row_addr,col_addr}.
- FIFO:
  - Push on wr_req && wr_ready; pop when the head is issued.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Push while full: ignored (wr_ready=0); this is the requester's responsibility.
  - Write latency: data accepted at edge k reaches the RAM no earlier than cycle k+1, and only on a free cycle with the fill idle and all older entries retired.
- Fill state machine:
  - IDLE: fill_start -> FILL; latch fill_color; row=col=0; fill_busy=1 from the next cycle.
  - FILL: each free cycle writes {row,col}.
    - col increments; col==COLS-1 wraps to 0 and row increments.
    - Write at row==ROWS-1, col==COLS-1 -> IDLE; fill_busy=0 the following cycle.
  - fill_start while busy: ignored; colour unchanged.
  - The FIFO keeps accepting during a fill but does not drain until the fill ends.
  - A fill needs exactly ROWS*COLS write cycles.
- All widths are unsigned; counters are exactly wide enough (row 9 bits, col 10 bits); no arithmetic overflow is reachable.

Test Plan:
- Reset: assert clrn=0 mid-traffic -> wr_ready=1, fill_busy=0, mem_we=0 immediately; after release, no write issued until a new request.
- Read priority: rdn=0, row_addr=5, col_addr=7, mem_rdata=12'hABC, with 2 FIFO entries pending -> mem_addr=19'h01407, mem_we=0, d_out=12'hABC; FIFO untouched.
- FIFO fill and drain:
  - Hold rdn=0; push 4 writes (rows 1..4, col 0) -> wr_ready=0 after the 4th, mem_we stays 0.
  - Raise rdn -> 4 consecutive mem_we pulses in push order, then wr_ready=1.
- Fill, rdn=1 constantly: pulse fill_start, fill_color=12'h0F0 -> first write addr {0,0}; {0,639} followed by {1,0}; last write {479,639}; exactly 307200 mem_we cycles, all data 12'h0F0; fill_busy then drops.
- Fill interleaved:
  - Real VGA timing on rdn, 1 FIFO write queued before fill_start -> mem_we never high while rdn=0.
  - All 307200 fill writes precede the queued write; a second fill_start mid-fill has no effect.
- Reset mid-fill: assert clrn after 1000 fill writes -> fill_busy=0, mem_we=0; a new fill_start restarts at {0,0}.
